// File: rtl/decoder_serializer.sv
// Wide-to-narrow serializer: one 2*no_of_units-element word out as two half-word beats,
// lower half first, with valid/ready on both sides, flush abort and a completed-word counter.
module decoder_serializer #(
  parameter int no_of_units   = 4,
  parameter int element_width = 32,
  parameter int COUNT_W       = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [2*element_width*no_of_units-1:0] in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [element_width*no_of_units-1:0] out_data,
  output logic                                 out_sel,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  input  logic                                 flush,
  output logic                                 busy,
  output logic [COUNT_W-1:0]                   word_count
);

  localparam int NW = element_width * no_of_units;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [2*NW-1:0] hold;
  logic            accept;

  // A new word can land in the same cycle the upper half leaves, so HI & out_ready opens the input.
  assign in_ready = !flush && ((state == IDLE) || ((state == HI) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = LO;
        LO:   if (out_ready) state_nxt = HI;
        HI:   if (out_ready) state_nxt = accept ? LO : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) hold <= in_data;
      if (!flush && (state == HI) && out_ready) word_count <= word_count + COUNT_W'(1);
    end
  end

  // Outputs decode from registered state and hold only; no input reaches them combinationally.
  always_comb begin
    out_data = '0;
    case (state)
      LO:      out_data = hold[NW-1:0];
      HI:      out_data = hold[2*NW-1:NW];
      default: out_data = '0;
    endcase
  end

  assign out_valid = (state != IDLE);
  assign out_sel   = (state == HI);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_decoder_serializer.sv
// Randomized self-checking bench for decoder_serializer against a queue-of-pending-beats model;
// a second instance with a 2-bit counter shares the inputs to exercise counter wrap.
module tb_decoder_serializer;
  localparam int NU = 4;
  localparam int EW = 32;
  localparam int NW = NU * EW;
  localparam int VW = NW + 22;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2*NW-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            flush = 1'b0;
  logic            in_ready, out_sel, out_valid, busy;
  logic [NW-1:0]   out_data;
  logic [15:0]     word_count;
  logic            in_ready2, out_sel2, out_valid2, busy2;
  logic [NW-1:0]   out_data2;
  logic [1:0]      word_count2;

  decoder_serializer #(.no_of_units(NU), .element_width(EW), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .busy(busy), .word_count(word_count));

  decoder_serializer #(.no_of_units(NU), .element_width(EW), .COUNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .out_data(out_data2), .out_sel(out_sel2), .out_valid(out_valid2), .out_ready(out_ready),
    .flush(flush), .busy(busy2), .word_count(word_count2));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit [NW:0]   beats[$];
  int unsigned m_count = 0;
  logic [VW-1:0] act;

  assign act = {out_valid, out_sel, out_data, in_ready, busy, word_count, word_count2};

  function automatic logic m_ready();
    return !flush && (beats.size() == 0 || (beats.size() == 1 && out_ready));
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic v, s;
    logic [NW-1:0] d;
    logic [15:0] c;
    v = (beats.size() != 0);
    s = v ? beats[0][NW] : 1'b0;
    d = v ? beats[0][NW-1:0] : '0;
    c = m_count[15:0];
    return {v, s, d, m_ready(), v, c, c[1:0]};
  endfunction

  function automatic logic [2*NW-1:0] rand_word();
    logic [2*NW-1:0] w;
    for (int i = 0; i < 2 * NU; i++) w[i*EW +: EW] = $urandom;
    return w;
  endfunction

  task automatic apply(input logic v, input logic [2*NW-1:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    #1;
  endtask

  task automatic advance();
    logic acc;
    bit [NW:0] b;
    acc = in_valid && m_ready();
    if (flush) beats.delete();
    else begin
      if (out_ready && beats.size() > 0) begin
        b = beats.pop_front();
        if (b[NW]) m_count++;
      end
      if (acc) begin
        beats.push_back({1'b0, in_data[NW-1:0]});
        beats.push_back({1'b1, in_data[2*NW-1:NW]});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_sel, out_data, busy, word_count, word_count2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs act=%h exp=0", {out_valid, out_sel, out_data, busy, word_count, word_count2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (act !== exp_vec() || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release act=%h exp=%h", act, exp_vec());
    end
    advance();
  endtask

  task automatic test_single();
    logic [2*NW-1:0] w;
    logic [15:0] base;
    w = {{NU{32'hBBBBBBBB}}, {NU{32'hAAAAAAAA}}};
    base = m_count[15:0];
    for (int c = 0; c < 4; c++) begin
      apply(c == 0, (c == 0) ? w : '0, 1'b1, 1'b0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL single_model c=%0d act=%h exp=%h", c, act, exp_vec());
      end
      checks++;
      if ((c == 1 && (out_valid !== 1'b1 || out_sel !== 1'b0 || out_data !== {NU{32'hAAAAAAAA}})) ||
          (c == 2 && (out_valid !== 1'b1 || out_sel !== 1'b1 || out_data !== {NU{32'hBBBBBBBB}})) ||
          (c == 3 && (out_valid !== 1'b0 || busy !== 1'b0 || word_count !== base + 16'd1))) begin
        errors++;
        $display("FAIL single_beat c=%0d valid=%b sel=%b data=%h cnt=%0d base=%0d", c, out_valid, out_sel, out_data, word_count, base);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [2*NW-1:0] w[3];
    int n;
    logic [15:0] base;
    for (int i = 0; i < 3; i++) w[i] = rand_word();
    n = 0;
    base = m_count[15:0];
    for (int c = 0; c < 8; c++) begin
      apply(n < 3, (n < 3) ? w[n] : '0, 1'b1, 1'b0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL b2b_model c=%0d act=%h exp=%h", c, act, exp_vec());
      end
      if (c >= 1 && c <= 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 1'((c - 1) % 2)) begin
          errors++; $display("FAIL b2b_beat c=%0d valid=%b sel=%b exp_sel=%0d", c, out_valid, out_sel, (c - 1) % 2);
        end
      end
      if (in_valid && m_ready()) n++;
      advance();
    end
    checks++;
    if (word_count !== base + 16'd3) begin
      errors++; $display("FAIL b2b_count act=%0d exp=%0d", word_count, base + 16'd3);
    end
  endtask

  task automatic test_backpressure();
    logic [2*NW-1:0] w;
    w = rand_word();
    apply(1'b1, w, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, rand_word(), 1'b0, 1'b0);
      checks++;
      if (act !== exp_vec() || out_sel !== 1'b0 || out_data !== w[NW-1:0] || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold i=%0d act=%h exp=%h", i, act, exp_vec());
      end
      advance();
    end
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (act !== exp_vec() || (c == 1 && (out_sel !== 1'b1 || out_data !== w[2*NW-1:NW]))) begin
        errors++; $display("FAIL bp_resume c=%0d act=%h exp=%h", c, act, exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_flush();
    logic [15:0] base;
    apply(1'b1, rand_word(), 1'b1, 1'b0);
    advance();
    apply(1'b0, '0, 1'b1, 1'b0);
    advance();
    base = m_count[15:0];
    apply(1'b1, rand_word(), 1'b1, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || out_sel !== 1'b1 || act !== exp_vec()) begin
      errors++; $display("FAIL flush_cycle in_ready=%b sel=%b act=%h exp=%h", in_ready, out_sel, act, exp_vec());
    end
    advance();
    apply(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || word_count !== base || act !== exp_vec()) begin
      errors++; $display("FAIL flush_after valid=%b busy=%b cnt=%0d exp_cnt=%0d", out_valid, busy, word_count, base);
    end
    advance();
  endtask

  task automatic test_async_reset();
    apply(1'b1, rand_word(), 1'b1, 1'b0);
    advance();
    apply(1'b0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || word_count !== 16'd0 || word_count2 !== 2'd0 || out_data !== '0) begin
      errors++; $display("FAIL async_reset valid=%b busy=%b cnt=%0d data=%h", out_valid, busy, word_count, out_data);
    end
    beats.delete();
    m_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL async_release act=%h exp=%h", act, exp_vec());
    end
    advance();
  endtask

  task automatic test_wrap();
    int seq[5] = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, rand_word(), 1'b1, 1'b0);
      advance();
      apply(1'b0, '0, 1'b1, 1'b0);
      advance();
      apply(1'b0, '0, 1'b1, 1'b0);
      advance();
      apply(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (word_count2 !== 2'(seq[k]) || act !== exp_vec()) begin
        errors++; $display("FAIL wrap k=%0d act=%0d exp=%0d", k, word_count2, seq[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      apply(1'($urandom_range(0, 1)), rand_word(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d act=%h exp=%h", c, act, exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
